// File: rtl/axi_mem_responder.sv
// axi_mem_responder
//   AXI4 slave memory model for pure-RTL simulation of the CPU AXI master port.
//   One 64-bit wide backing store, independent read and write engines, one
//   outstanding transaction per direction, FIXED/INCR bursts, byte strobes and
//   a fixed read latency of RD_DELAY cycles from AR accept to the first R beat.
// Ports
//   clock, reset                     : single clock, synchronous active-high reset
//   axi_aw* / axi_awready            : write address channel (id, addr, len, size, burst)
//   axi_w*  / axi_wready             : write data channel (data, strb, last)
//   axi_b*  / axi_bready             : write response channel (id, resp)
//   axi_ar* / axi_arready            : read address channel (id, addr, len, size, burst)
//   axi_r*  / axi_rready             : read data channel (id, data, resp, last)
//   Responses: 00 OKAY, 10 SLVERR (WRAP burst or wlast misplaced), 11 DECERR (unmapped).
module axi_mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          MEM_WORDS = 65536,
  parameter int          RD_DELAY  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  axi_awid,
  input  logic [31:0] axi_awaddr,
  input  logic [7:0]  axi_awlen,
  input  logic [2:0]  axi_awsize,
  input  logic [1:0]  axi_awburst,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [63:0] axi_wdata,
  input  logic [7:0]  axi_wstrb,
  input  logic        axi_wlast,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [3:0]  axi_bid,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  input  logic [3:0]  axi_arid,
  input  logic [31:0] axi_araddr,
  input  logic [7:0]  axi_arlen,
  input  logic [2:0]  axi_arsize,
  input  logic [1:0]  axi_arburst,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  output logic [3:0]  axi_rid,
  output logic [63:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rlast,
  output logic        axi_rvalid,
  input  logic        axi_rready
);

  localparam int          IDX_W       = $clog2(MEM_WORDS);
  localparam logic [32:0] SPAN        = 33'(MEM_WORDS) << 3;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;
  localparam logic [1:0]  BURST_INCR  = 2'b01;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic [63:0] mem [MEM_WORDS];

  // Per-beat response; burst[1] set covers WRAP and the reserved encoding.
  function automatic logic [1:0] beat_resp(input logic [31:0] addr, input logic [1:0] burst);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, BASE_ADDR};
    if (burst[1]) return RESP_SLVERR;
    if (off[32] || off >= SPAN) return RESP_DECERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> 3);
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                            input logic [1:0] burst);
    return (burst == BURST_INCR) ? addr + (32'd1 << size) : addr;
  endfunction

  // ---------------- read engine ----------------
  logic [1:0]  r_state;
  logic [7:0]  r_cnt, r_len, r_beat;
  logic [31:0] r_addr;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic [31:0] r_addr_nxt, r_fetch;
  logic [1:0]  r_fetch_resp;
  logic [63:0] r_fetch_data;

  // In R_WAIT the first beat comes from the latched address; in R_DATA a
  // handshake fetches the following beat so rvalid never drops mid-burst.
  assign r_addr_nxt   = next_addr(r_addr, r_size, r_burst);
  assign r_fetch      = (r_state == R_DATA) ? r_addr_nxt : r_addr;
  assign r_fetch_resp = beat_resp(r_fetch, r_burst);
  assign r_fetch_data = (r_fetch_resp == RESP_OKAY) ? mem[word_idx(r_fetch)] : 64'd0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= R_IDLE;
      r_cnt       <= 8'd0;
      axi_arready <= 1'b0;
      axi_rvalid  <= 1'b0;
      axi_rdata   <= 64'd0;
      axi_rresp   <= RESP_OKAY;
      axi_rlast   <= 1'b0;
      axi_rid     <= 4'd0;
    end else begin
      case (r_state)
        R_IDLE: begin
          axi_arready <= 1'b1;
          if (axi_arready && axi_arvalid) begin
            axi_arready <= 1'b0;
            axi_rid     <= axi_arid;
            r_addr      <= axi_araddr;
            r_len       <= axi_arlen;
            r_size      <= axi_arsize;
            r_burst     <= axi_arburst;
            r_beat      <= 8'd0;
            r_cnt       <= 8'd0;
            r_state     <= R_WAIT;
          end
        end
        R_WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          if (r_cnt == 8'(RD_DELAY - 1)) begin
            axi_rvalid <= 1'b1;
            axi_rdata  <= r_fetch_data;
            axi_rresp  <= r_fetch_resp;
            axi_rlast  <= (r_len == 8'd0);
            r_state    <= R_DATA;
          end
        end
        R_DATA: begin
          if (axi_rready) begin
            if (axi_rlast) begin
              axi_rvalid  <= 1'b0;
              axi_rlast   <= 1'b0;
              axi_arready <= 1'b1;
              r_state     <= R_IDLE;
            end else begin
              r_addr    <= r_addr_nxt;
              r_beat    <= r_beat + 8'd1;
              axi_rdata <= r_fetch_data;
              axi_rresp <= r_fetch_resp;
              axi_rlast <= ((r_beat + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------- write engine ----------------
  logic [1:0]  w_state;
  logic [7:0]  w_len, w_beat;
  logic [31:0] w_addr;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic [1:0]  w_err;
  logic        w_hs, w_last_exp, mem_we;
  logic [1:0]  w_beat_resp, w_err_beat, w_err_acc;

  assign w_hs        = axi_wready && axi_wvalid;
  assign w_last_exp  = (w_beat == w_len);
  assign w_beat_resp = beat_resp(w_addr, w_burst);
  // Address/burst errors take precedence over a misplaced wlast on the same beat;
  // the burst keeps the first non-OKAY value.
  assign w_err_beat  = (w_beat_resp != RESP_OKAY) ? w_beat_resp :
                       ((axi_wlast != w_last_exp) ? RESP_SLVERR : RESP_OKAY);
  assign w_err_acc   = (w_err != RESP_OKAY) ? w_err : w_err_beat;
  assign mem_we      = w_hs && !reset && (w_state == W_DATA) && (w_beat_resp == RESP_OKAY);

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state     <= W_IDLE;
      axi_awready <= 1'b0;
      axi_wready  <= 1'b0;
      axi_bvalid  <= 1'b0;
      axi_bresp   <= RESP_OKAY;
      axi_bid     <= 4'd0;
    end else begin
      case (w_state)
        W_IDLE: begin
          axi_awready <= 1'b1;
          if (axi_awready && axi_awvalid) begin
            axi_awready <= 1'b0;
            axi_wready  <= 1'b1;
            axi_bid     <= axi_awid;
            w_addr      <= axi_awaddr;
            w_len       <= axi_awlen;
            w_size      <= axi_awsize;
            w_burst     <= axi_awburst;
            w_beat      <= 8'd0;
            w_err       <= RESP_OKAY;
            w_state     <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_err <= w_err_acc;
            // Beat count alone ends the burst; wlast only affects bresp.
            if (w_last_exp) begin
              axi_wready <= 1'b0;
              axi_bvalid <= 1'b1;
              axi_bresp  <= w_err_acc;
              w_state    <= W_RESP;
            end else begin
              w_addr <= next_addr(w_addr, w_size, w_burst);
              w_beat <= w_beat + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (axi_bready) begin
            axi_bvalid  <= 1'b0;
            axi_awready <= 1'b1;
            w_state     <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Storage is never cleared; a read of the same word in the same cycle sees old data.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (axi_wstrb[i]) mem[word_idx(w_addr)][8*i +: 8] <= axi_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
module tb_axi_mem_responder;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          WORDS = 65536;
  localparam int          DLY   = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  axi_awid = '0;
  logic [31:0] axi_awaddr = '0;
  logic [7:0]  axi_awlen = '0;
  logic [2:0]  axi_awsize = '0;
  logic [1:0]  axi_awburst = '0;
  logic        axi_awvalid = 1'b0;
  logic        axi_awready;
  logic [63:0] axi_wdata = '0;
  logic [7:0]  axi_wstrb = '0;
  logic        axi_wlast = 1'b0;
  logic        axi_wvalid = 1'b0;
  logic        axi_wready;
  logic [3:0]  axi_bid;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready = 1'b0;
  logic [3:0]  axi_arid = '0;
  logic [31:0] axi_araddr = '0;
  logic [7:0]  axi_arlen = '0;
  logic [2:0]  axi_arsize = '0;
  logic [1:0]  axi_arburst = '0;
  logic        axi_arvalid = 1'b0;
  logic        axi_arready;
  logic [3:0]  axi_rid;
  logic [63:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic        axi_rvalid;
  logic        axi_rready = 1'b0;

  always #5 clock = ~clock;

  axi_mem_responder #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS), .RD_DELAY(DLY)) dut (
    .clock(clock), .reset(reset),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  rbeat_t      rq[$];
  logic [63:0] mdl [int];
  logic [63:0] wd [16];
  logic [7:0]  ws [16];

  function automatic logic [1:0] m_resp(input logic [31:0] a, input logic [1:0] burst);
    if (burst == 2'b10) return 2'b10;
    if (a < BASE || a >= BASE + 32'(8 * WORDS)) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [31:0] m_addr(input logic [31:0] a, input logic [2:0] size,
                                         input logic [1:0] burst, input int b);
    return (burst == 2'b01) ? a + 32'(b) * (32'd1 << size) : a;
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) >> 3);
  endfunction

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    rbeat_t e;
    logic [31:0] a;
    int n;
    for (int b = 0; b <= int'(len); b++) begin
      a = m_addr(addr, size, burst, b);
      e.id   = id;
      e.resp = m_resp(a, burst);
      e.data = (e.resp == 2'b00 && mdl.exists(m_idx(a))) ? mdl[m_idx(a)] : 64'd0;
      e.last = (b == int'(len));
      rq.push_back(e);
    end
    axi_arid = id; axi_araddr = addr; axi_arlen = len; axi_arsize = size; axi_arburst = burst;
    axi_arvalid = 1'b1;
    n = 0;
    while (!axi_arready && n < 50) begin @(negedge clock); n++; end
    if (!axi_arready) begin
      checks++; errors++;
      $display("FAIL ar_accept: arready stayed %0b, want 1", axi_arready);
    end else begin
      @(negedge clock);
    end
    axi_arvalid = 1'b0;
  endtask

  task automatic collect_reads();
    rbeat_t e;
    int n;
    n = 0;
    axi_rready = 1'b1;
    while (rq.size() > 0 && n < 200) begin
      if (axi_rvalid) begin
        e = rq.pop_front();
        checks++;
        if ({axi_rid, axi_rdata, axi_rresp, axi_rlast} !== {e.id, e.data, e.resp, e.last}) begin
          errors++;
          $display("FAIL rbeat: got id=%0h data=%h resp=%0b last=%0b, want id=%0h data=%h resp=%0b last=%0b",
                   axi_rid, axi_rdata, axi_rresp, axi_rlast, e.id, e.data, e.resp, e.last);
        end
      end
      @(negedge clock);
      n++;
    end
    if (rq.size() > 0) begin
      checks++; errors++;
      $display("FAIL read_drain: %0d beats outstanding, want 0", rq.size());
      rq.delete();
    end
    axi_rready = 1'b0;
  endtask

  // Drives one write burst from wd/ws and compares the B response with the model.
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int lastpos);
    logic [1:0]  acc, e;
    logic [31:0] a;
    logic [63:0] w;
    int n;
    acc = 2'b00;
    for (int b = 0; b <= int'(len); b++) begin
      a = m_addr(addr, size, burst, b);
      e = m_resp(a, burst);
      if (e == 2'b00) begin
        w = mdl.exists(m_idx(a)) ? mdl[m_idx(a)] : 64'd0;
        for (int i = 0; i < 8; i++) if (ws[b][i]) w[8*i +: 8] = wd[b][8*i +: 8];
        mdl[m_idx(a)] = w;
        if ((b == lastpos) != (b == int'(len))) e = 2'b10;
      end
      if (acc == 2'b00) acc = e;
    end
    axi_awid = id; axi_awaddr = addr; axi_awlen = len; axi_awsize = size; axi_awburst = burst;
    axi_awvalid = 1'b1;
    n = 0;
    while (!axi_awready && n < 50) begin @(negedge clock); n++; end
    if (!axi_awready) begin
      checks++; errors++;
      $display("FAIL aw_accept: awready stayed %0b, want 1", axi_awready);
    end else begin
      @(negedge clock);
    end
    axi_awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      axi_wdata = wd[b]; axi_wstrb = ws[b]; axi_wlast = (b == lastpos); axi_wvalid = 1'b1;
      n = 0;
      while (!axi_wready && n < 50) begin @(negedge clock); n++; end
      if (!axi_wready) begin
        checks++; errors++;
        $display("FAIL w_accept: beat %0d wready stayed %0b, want 1", b, axi_wready);
      end
      @(negedge clock);
    end
    axi_wvalid = 1'b0; axi_wlast = 1'b0;
    axi_bready = 1'b1;
    n = 0;
    while (!axi_bvalid && n < 50) begin @(negedge clock); n++; end
    checks++;
    if ({axi_bvalid, axi_bid, axi_bresp} !== {1'b1, id, acc}) begin
      errors++;
      $display("FAIL bresp: got valid=%0b id=%0h resp=%0b, want valid=1 id=%0h resp=%0b",
               axi_bvalid, axi_bid, axi_bresp, id, acc);
    end
    @(negedge clock);
    axi_bready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({axi_awready, axi_wready, axi_arready} !== 3'b000) begin
      errors++; $display("FAIL reset_ready: got aw/w/ar=%b, want 000", {axi_awready, axi_wready, axi_arready});
    end
    checks++;
    if ({axi_bvalid, axi_rvalid, axi_rlast} !== 3'b000) begin
      errors++; $display("FAIL reset_valid: got b/r/last=%b, want 000", {axi_bvalid, axi_rvalid, axi_rlast});
    end
    checks++;
    if ({axi_rid, axi_rdata, axi_rresp, axi_bid, axi_bresp} !== '0) begin
      errors++; $display("FAIL reset_fields: got rid=%0h rdata=%h rresp=%0b bid=%0h bresp=%0b, want all 0",
                         axi_rid, axi_rdata, axi_rresp, axi_bid, axi_bresp);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({axi_awready, axi_arready} !== 2'b11) begin
      errors++; $display("FAIL post_reset_ready: got aw/ar=%b, want 11", {axi_awready, axi_arready});
    end
    checks++;
    if ({axi_bvalid, axi_rvalid, axi_wready} !== 3'b000) begin
      errors++; $display("FAIL post_reset_valid: got b/r/wready=%b, want 000", {axi_bvalid, axi_rvalid, axi_wready});
    end
  endtask

  task automatic test_single();
    int n;
    wd[0] = 64'h1122_3344_5566_7788; ws[0] = 8'hFF;
    do_write(4'd3, BASE, 8'd0, 3'd3, 2'b01, 0);
    ar_send(4'd5, BASE, 8'd0, 3'd3, 2'b01);
    n = 0;
    while (!axi_rvalid && n < 20) begin @(negedge clock); n++; end
    checks++;
    if (n !== DLY) begin
      errors++; $display("FAIL read_latency: got %0d cycles, want %0d", n, DLY);
    end
    collect_reads();
  endtask

  task automatic test_incr_burst();
    for (int i = 0; i < 4; i++) begin wd[i] = 64'hA5A5_0000_0000_0000 | 64'(i); ws[i] = 8'hFF; end
    do_write(4'd1, BASE + 32'h100, 8'd3, 3'd3, 2'b01, 3);
    for (int i = 0; i < 4; i++) begin wd[i] = 64'(i + 1); ws[i] = 8'hFF; end
    ws[2] = 8'h0F;
    do_write(4'd2, BASE + 32'h100, 8'd3, 3'd3, 2'b01, 3);
    ar_send(4'd4, BASE + 32'h100, 8'd3, 3'd3, 2'b01);
    collect_reads();
  endtask

  task automatic test_backpressure();
    rbeat_t e;
    int n;
    ar_send(4'd7, BASE + 32'h100, 8'd1, 3'd3, 2'b01);
    n = 0;
    while (!axi_rvalid && n < 20) begin @(negedge clock); n++; end
    e = rq.pop_front();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast} !== {1'b1, e.id, e.data, e.resp, e.last}) begin
        errors++; $display("FAIL hold_beat0 cycle %0d: got valid=%0b data=%h last=%0b, want valid=1 data=%h last=%0b",
                           k, axi_rvalid, axi_rdata, axi_rlast, e.data, e.last);
      end
      @(negedge clock);
    end
    axi_rready = 1'b1;
    @(negedge clock);
    e = rq.pop_front();
    checks++;
    if ({axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast} !== {1'b1, e.id, e.data, e.resp, e.last}) begin
      errors++; $display("FAIL beat1_next: got valid=%0b data=%h last=%0b, want valid=1 data=%h last=%0b",
                         axi_rvalid, axi_rdata, axi_rlast, e.data, e.last);
    end
    @(negedge clock);
    axi_rready = 1'b0;
    checks++;
    if (axi_rvalid !== 1'b0) begin
      errors++; $display("FAIL burst_end: got rvalid=%0b, want 0", axi_rvalid);
    end
  endtask

  task automatic test_errors();
    ar_send(4'd1, 32'h0000_0000, 8'd0, 3'd3, 2'b01);
    collect_reads();
    wd[0] = 64'h0F0E_0D0C_0B0A_0908; ws[0] = 8'hFF;
    do_write(4'd6, BASE + 32'(8 * WORDS) - 32'd8, 8'd0, 3'd3, 2'b01, 0);
    ar_send(4'd2, BASE + 32'(8 * WORDS) - 32'd8, 8'd1, 3'd3, 2'b01);
    collect_reads();
    wd[0] = 64'hDEAD_BEEF_DEAD_BEEF; ws[0] = 8'hFF;
    do_write(4'd8, BASE, 8'd0, 3'd3, 2'b10, 0);
    do_write(4'd9, 32'h7FFF_FFF8, 8'd0, 3'd3, 2'b01, 0);
    ar_send(4'd3, BASE, 8'd0, 3'd3, 2'b01);
    collect_reads();
  endtask

  task automatic test_fixed();
    wd[0] = 64'h1111_1111_1111_1111; wd[1] = 64'h2222_2222_2222_2222;
    ws[0] = 8'hFF; ws[1] = 8'hFF;
    do_write(4'd5, BASE + 32'h200, 8'd1, 3'd3, 2'b00, 1);
    ar_send(4'd6, BASE + 32'h200, 8'd1, 3'd3, 2'b00);
    collect_reads();
  endtask

  task automatic test_wlast_err();
    for (int i = 0; i < 3; i++) begin wd[i] = 64'h3000 + 64'(i); ws[i] = 8'hFF; end
    do_write(4'hC, BASE + 32'h300, 8'd2, 3'd3, 2'b01, 1);
  endtask

  task automatic test_back_to_back();
    wd[0] = 64'h4444_5555_6666_7777; ws[0] = 8'hFF;
    fork
      do_write(4'hA, BASE + 32'h400, 8'd0, 3'd3, 2'b01, 0);
      begin
        ar_send(4'hB, BASE + 32'h100, 8'd3, 3'd3, 2'b01);
        collect_reads();
      end
    join
    ar_send(4'hD, BASE + 32'h400, 8'd0, 3'd3, 2'b01);
    collect_reads();
  endtask

  task automatic test_reset_mid();
    int n;
    ar_send(4'd2, BASE + 32'h100, 8'd3, 3'd3, 2'b01);
    n = 0;
    while (!axi_rvalid && n < 20) begin @(negedge clock); n++; end
    reset = 1'b1;
    @(negedge clock);
    rq.delete();
    checks++;
    if ({axi_rvalid, axi_arready} !== 2'b00) begin
      errors++; $display("FAIL reset_mid: got rvalid/arready=%b, want 00", {axi_rvalid, axi_arready});
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({axi_arready, axi_awready, axi_rvalid} !== 3'b110) begin
      errors++; $display("FAIL reset_mid_recover: got ar/aw/rvalid=%b, want 110",
                         {axi_arready, axi_awready, axi_rvalid});
    end
    ar_send(4'd4, BASE, 8'd0, 3'd3, 2'b01);
    collect_reads();
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr_burst();
    test_backpressure();
    test_errors();
    test_fixed();
    test_wlast_err();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
